// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and types for the multiplexed 7-segment scanner
package disp_pkg;

    localparam int NUM_DIGITS = 6;

    // Full segment bytes {dp,g,f,e,d,c,b,a}, active-low
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low a-g glyphs for BCD 0..9 (bit6 = g ... bit0 = a)
    localparam logic [6:0] GLYPH [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Digit slot index; D0 = hour tens ... D5 = second units
    typedef enum logic [2:0] {
        D0 = 3'd0,
        D1 = 3'd1,
        D2 = 3'd2,
        D3 = 3'd3,
        D4 = 3'd4,
        D5 = 3'd5
    } digit_idx_t;

    // blink_sel field encoding
    localparam logic [1:0] BLINK_NONE    = 2'b00;
    localparam logic [1:0] BLINK_HOURS   = 2'b01;
    localparam logic [1:0] BLINK_MINUTES = 2'b10;
    localparam logic [1:0] BLINK_SECONDS = 2'b11;

endpackage

// File: rtl/disp_scan_7seg_if.sv
// rtl/disp_scan_7seg_if.sv - time-digit interface between the counter chain and the display scanner
interface disp_scan_7seg_if;

    logic [3:0] hour_g;
    logic [3:0] hour_d;
    logic [3:0] minute_g;
    logic [3:0] minute_d;
    logic [3:0] second_g;
    logic [3:0] second_d;
    logic [1:0] blink_sel;

    // Counter chain side
    modport master (
        output hour_g, hour_d, minute_g, minute_d, second_g, second_d, blink_sel
    );

    // Display reader side
    modport slave (
        input hour_g, hour_d, minute_g, minute_d, second_g, second_d, blink_sel
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to active-low a-g decoder, dash for codes 10-15
module bcd_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg7
);

    // Table lookup; non-decimal codes show a lone g segment
    always_comb begin
        seg7 = SEG_DASH[6:0];
        case (bcd)
            4'd0:    seg7 = GLYPH[0];
            4'd1:    seg7 = GLYPH[1];
            4'd2:    seg7 = GLYPH[2];
            4'd3:    seg7 = GLYPH[3];
            4'd4:    seg7 = GLYPH[4];
            4'd5:    seg7 = GLYPH[5];
            4'd6:    seg7 = GLYPH[6];
            4'd7:    seg7 = GLYPH[7];
            4'd8:    seg7 = GLYPH[8];
            4'd9:    seg7 = GLYPH[9];
            default: seg7 = SEG_DASH[6:0];
        endcase
    end

endmodule

// File: rtl/disp_scan_7seg.sv
// rtl/disp_scan_7seg.sv - 6-digit multiplexed 7-segment scanner with frame shadow and field blink (optional DISP_LZB_EN: blank zero hour tens)
module disp_scan_7seg
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
)
(
    input  logic                  clk,
    input  logic                  reset,
    disp_scan_7seg_if.slave       digits,
    output logic [7:0]            seg,
    output logic [5:0]            an
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;
    digit_idx_t    idx_q, idx_d;
    logic          frame_start;
    logic [3:0]    shadow_q [NUM_DIGITS];
    logic [3:0]    shadow_d [NUM_DIGITS];
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;
    logic [3:0]    cur_bcd;
    logic          in_field;
    logic [6:0]    glyph;
    logic          lzb_blank;
    logic [7:0]    seg_d;
    logic [5:0]    an_d;

    assign tick        = (pre_cnt == PW'(SCAN_DIV - 1));
    // Leaving D5 means the next slot is D0: the frame boundary
    assign frame_start = tick && (idx_q == D5);

    // Slot prescaler: one tick every SCAN_DIV clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + PW'(1);
    end

    // Digit-select state register; parks on D5 so the first tick starts a frame at D0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idx_q <= D5;
        else        idx_q <= idx_d;
    end

    // Digit-select next state: advance one slot per tick, D5 wraps to D0
    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            case (idx_q)
                D0:      idx_d = D1;
                D1:      idx_d = D2;
                D2:      idx_d = D3;
                D3:      idx_d = D4;
                D4:      idx_d = D5;
                default: idx_d = D0;
            endcase
        end
    end

    // Shadow next value: capture all six digits together at frame start
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) shadow_d[i] = shadow_q[i];
        if (frame_start) begin
            shadow_d[0] = digits.hour_g;
            shadow_d[1] = digits.hour_d;
            shadow_d[2] = digits.minute_g;
            shadow_d[3] = digits.minute_d;
            shadow_d[4] = digits.second_g;
            shadow_d[5] = digits.second_d;
        end
    end

    // Shadow register holding the time shown during the current frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    // Frame counter and blink phase next values, toggling every BLINK_FRAMES frames
    always_comb begin
        frame_d = frame_q;
        blink_d = blink_q;
        if (frame_start) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    // Frame counter and blink phase registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q <= '0;
            blink_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            blink_q <= blink_d;
        end
    end

    // Select the digit for the upcoming slot and whether it belongs to the flashed field
    always_comb begin
        cur_bcd  = shadow_d[0];
        in_field = 1'b0;
        case (idx_d)
            D0: begin cur_bcd = shadow_d[0]; in_field = (digits.blink_sel == BLINK_HOURS);   end
            D1: begin cur_bcd = shadow_d[1]; in_field = (digits.blink_sel == BLINK_HOURS);   end
            D2: begin cur_bcd = shadow_d[2]; in_field = (digits.blink_sel == BLINK_MINUTES); end
            D3: begin cur_bcd = shadow_d[3]; in_field = (digits.blink_sel == BLINK_MINUTES); end
            D4: begin cur_bcd = shadow_d[4]; in_field = (digits.blink_sel == BLINK_SECONDS); end
            D5: begin cur_bcd = shadow_d[5]; in_field = (digits.blink_sel == BLINK_SECONDS); end
            default: begin cur_bcd = shadow_d[0]; in_field = 1'b0; end
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd  (cur_bcd),
        .seg7 (glyph)
    );

`ifdef DISP_LZB_EN
    assign lzb_blank = (idx_d == D0) && (cur_bcd == 4'd0);
`else
    assign lzb_blank = 1'b0;
`endif

    // Compose the next segment byte: dp separators on D1/D3, blink and blanking clear a-g only
    always_comb begin
        seg_d = {~((idx_d == D1) || (idx_d == D3)), glyph};
        if ((blink_d && in_field) || lzb_blank) seg_d[6:0] = 7'h7F;
        an_d  = ~(6'b000001 << idx_d);
    end

    // Registered pin drivers; dark from reset until the first slot boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_BLANK;
            an  <= 6'h3F;
        end else if (tick) begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_disp_scan_7seg.sv
// tb/tb_disp_scan_7seg.sv - directed self-checking bench for disp_scan_7seg
module tb_disp_scan_7seg;

    localparam int SCAN = 4;

    // Active-low a-g glyphs, codes 10-15 are the dash
    localparam logic [6:0] GL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] seg;
    logic [5:0] an;
    int         checks   = 0;
    int         failures = 0;

    disp_scan_7seg_if tif ();

    disp_scan_7seg #(.SCAN_DIV(SCAN), .BLINK_FRAMES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .digits (tif.slave),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int d, input logic [3:0] v,
                                           input logic blk, input logic [1:0] sel);
        logic [7:0] e;
        e[7]   = !(d == 1 || d == 3);
        e[6:0] = GL[v];
        if (blk && sel != 2'b00 && (d / 2) + 1 == int'(sel)) e[6:0] = 7'h7F;
`ifdef DISP_LZB_EN
        if (d == 0 && v == 4'd0) e[6:0] = 7'h7F;
`endif
        return e;
    endfunction

    task automatic set_time(input logic [3:0] hg, hd, mg, md, sg, sd);
        tif.hour_g = hg; tif.hour_d = hd; tif.minute_g = mg;
        tif.minute_d = md; tif.second_g = sg; tif.second_d = sd;
    endtask

    // Release reset at a falling edge and confirm the display stays dark until the first tick
    task automatic release_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        repeat (SCAN - 1) @(negedge clk);
        chk({tag, "_dark_seg"}, seg, 8'hFF);
        chk({tag, "_dark_an"}, an, 6'h3F);
    endtask

    // Check one full frame; inputs present now are those captured at this frame's start
    task automatic frame_check(input string tag, input logic blk, input int chg_slot);
        logic [3:0] snap [6];
        logic [5:0] an_exp;
        snap[0] = tif.hour_g;   snap[1] = tif.hour_d;
        snap[2] = tif.minute_g; snap[3] = tif.minute_d;
        snap[4] = tif.second_g; snap[5] = tif.second_d;
        for (int d = 0; d < 6; d++) begin
            @(negedge clk);
            an_exp = ~(6'b000001 << d);
            chk($sformatf("%s_an_d%0d", tag, d), an, an_exp);
            chk($sformatf("%s_seg_d%0d", tag, d), seg, exp_seg(d, snap[d], blk, tif.blink_sel));
            if (d == chg_slot) tif.minute_d = 4'd5;
            repeat (SCAN - 1) @(negedge clk);
        end
    endtask

    initial begin
        int         bad_hot, bad_len, run, changes;
        logic [5:0] prev;
        logic [5:0] an_exp;

        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        tif.blink_sel = 2'b00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 6'h3F);

        // 12:34:56 scan, then minute_d changes during D2 of the first frame
        release_reset("t1");
        frame_check("t1_f1", 1'b0, 2);
        frame_check("t2_f2", 1'b0, -1);

        // Asynchronous reset during D4
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            an_exp = ~(6'b000001 << d);
            chk($sformatf("t5_an_d%0d", d), an, an_exp);
            repeat (SCAN - 1) @(negedge clk);
        end
        @(negedge clk);
        chk("t5_an_d4", an, 6'h2F);
        chk("t5_seg_d4", seg, 8'h92);
        reset = 1'b0;
        #1;
        chk("t5_async_seg", seg, 8'hFF);
        chk("t5_async_an", an, 6'h3F);
        tif.blink_sel = 2'b10;
        repeat (2) @(negedge clk);
        chk("t5_held_an", an, 6'h3F);

        // Minutes blink with BLINK_FRAMES=2: phase per frame 0,1,1,0,0,1
        release_reset("t5");
        frame_check("t3_f1", 1'b0, -1);
        frame_check("t3_f2", 1'b1, -1);
        frame_check("t3_f3", 1'b1, -1);
        frame_check("t3_f4", 1'b0, -1);
        frame_check("t3_f5", 1'b0, -1);
        frame_check("t3_f6", 1'b1, -1);

        // Invalid hour tens shows a dash, zero hour tens per build option
        tif.blink_sel = 2'b00;
        tif.hour_g = 4'hC;
        frame_check("t4_dash", 1'b0, -1);
        tif.hour_g = 4'h0;
        frame_check("t4_zero", 1'b0, -1);

        // 1000 slots: one-hot-low enables and constant slot length
        bad_hot = 0; bad_len = 0; changes = 0;
        run  = SCAN - 1;
        prev = an;
        for (int c = 0; c < 1000 * SCAN; c++) begin
            @(negedge clk);
            if ($countones(~an) != 1) bad_hot++;
            run++;
            if (an != prev) begin
                if (run != SCAN) bad_len++;
                changes++;
                run  = 0;
                prev = an;
            end
        end
        chk("t6_onehot_violations", bad_hot, 0);
        chk("t6_slot_len_violations", bad_len, 0);
        chk("t6_slot_count", changes, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_scan_7seg.md
Name: disp_scan_7seg

Overview:
Reader side of the time-digit interface. Consumes the six BCD digits (hour/minute/second tens and units) produced by the counter chain and drives a 6-digit multiplexed common-anode 7-segment display. Contains a scan prescaler, a digit-select state machine, a frame-coherent shadow register and a blink timer that flashes the field currently being set. Sits between the counter chain and the board pins.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot; legal range is 2 or more.
BLINK_FRAMES, 64, full 6-digit frames per blink half-period; legal range is 1 or more.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
hour_g  input  4  hour tens, BCD
hour_d  input  4  hour units, BCD
minute_g  input  4  minute tens, BCD
minute_d  input  4  minute units, BCD
second_g  input  4  second tens, BCD
second_d  input  4  second units, BCD
blink_sel  input  2  field to flash: 00 none, 01 hours, 10 minutes, 11 seconds
seg  output  8  {dp,g,f,e,d,c,b,a}, active-low
an  output  6  digit enables, active-low; bit0 = hour_g ... bit5 = second_d

Behaviour:
- Reset (async assert, sync release): all counters 0, shadow digits 0, blink phase 0 (visible). seg=8'hFF and an=6'h3F (display dark) until the first slot boundary after release.
- Prescaler counts 0..SCAN_DIV-1. Wrap is the slot tick.
- Digit index states are D0..D5 and advance one per tick. D5 wraps to D0.
- Frame start is the tick that moves the index to D0:
  - all six inputs are copied into the shadow register in that cycle, so a frame never mixes old and new time;
  - the frame counter increments;
  - when the frame counter reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- Outputs are registered. seg and an change together exactly one clk after the tick, from the shadow value of the new index.
- Exactly one an bit is low in any cycle after the first tick.
- Decode table: 0-9 give standard glyphs. Codes 10-15 give "-" (segment g only, seg=8'hBF).
- Decimal point is lit on D1 and D3 (hh.mm.ss separators) and off elsewhere. The blink does not affect it.
- Blink: when the blink phase is 1 and the current digit belongs to the blink_sel field, segments a-g are forced off while the dp rule still applies and an stays active. This keeps the scan timing constant.
- blink_sel is sampled combinationally at each tick (not shadowed). A change takes effect from the next digit slot.
- Reset mid-frame: immediately dark. The scan restarts from the D0 slot.
- Simultaneous frame start and blink toggle in the same cycle: the new shadow value and the new phase apply together to D0.

Optional Feature:
DISP_LZB_EN. When defined, leading-zero blanking applies: if shadow hour_g==0, D0 shows all segments off, while an still strobes. When undefined, D0 shows "0" normally. The feature has no effect on any other digit.

Decomposition:
- Package disp_pkg holds:
  - NUM_DIGITS=6;
  - SEG_BLANK=8'hFF and SEG_DASH=8'hBF;
  - the 10-entry glyph constant array;
  - the digit-index typedef (3-bit);
  - the blink_sel encoding constants.
- One natural sub-module, bcd_to_7seg: a pure combinational 4-bit to 7-bit decoder including the dash for invalid codes. dp and blink gating stay in the parent.

Test Plan:
1. Use SCAN_DIV=4 with inputs 12:34:56 and blink_sel=00. After reset release, the an sequence is 3E,3D,3B,37,2F,1F, each held 4 clk. The matching seg values (a-g) are the glyphs 1,2,3,4,5,6. dp is low only on D1 and D3.
2. Change minute_d 4->5 while mid-frame at D2. D3 still shows 4 for the rest of that frame. D3 shows 5 from the next frame on.
3. Set BLINK_FRAMES=2 and blink_sel=10. On D2 and D3, seg[6:0] is 7F for 2 frames and then shows glyphs for 2 frames, repeating. D3's dp stays lit throughout. The other digits are unaffected.
4. Drive hour_g=4'hC. D0 shows seg=BF. With DISP_LZB_EN and hour_g=0, D0 shows FF while an[0] still goes low for its slot.
5. Assert reset during D4. Within 0 clk (async) seg=FF and an=3F. After release, the first lit digit is D0 following SCAN_DIV cycles.
6. Run 1000 slots. Every cycle after the first tick has exactly one an bit low, and the slot length is always SCAN_DIV.
